// File: rtl/exec_alu_seq.sv
// exec_alu_seq: registered, handshaked execute-stage ALU (RV32I ALU ops, optional iterative M ops).
// Define EXEC_ALU_MULDIV_EN to enable the multiply/divide unit (codes 16-23); otherwise they are illegal.
module exec_alu_seq #(
  parameter int unsigned LEN   = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op_sel,
  input  logic [LEN-1:0]   opa,
  input  logic [LEN-1:0]   opb,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN-1:0]   result,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_zero,
  output logic             flag_lt,
  output logic             flag_ltu,
  output logic             illegal
);
  localparam int unsigned SH_W = $clog2(LEN);

`ifdef EXEC_ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t           state_q;
  logic             out_valid_q, zero_q, lt_q, ltu_q, illegal_q;
  logic [LEN-1:0]   result_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             accept, eq, slt, sltu, base_ok;
  logic [LEN-1:0]   base_d;
  logic [SH_W-1:0]  shamt;

  assign in_ready = rdy_in && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign shamt    = opb[SH_W-1:0];
  assign eq       = (opa == opb);
  assign slt      = ($signed(opa) < $signed(opb));
  assign sltu     = (opa < opb);

  always_comb begin
    base_d  = '0;
    base_ok = 1'b1;
    case (op_sel)
      5'd0:    base_d = opa + opb;
      5'd1:    base_d = opa - opb;
      5'd2:    base_d = opa << shamt;
      5'd3:    base_d = {{(LEN-1){1'b0}}, slt};
      5'd4:    base_d = {{(LEN-1){1'b0}}, sltu};
      5'd5:    base_d = opa ^ opb;
      5'd6:    base_d = opa >> shamt;
      5'd7:    base_d = $signed(opa) >>> shamt;
      5'd8:    base_d = opa | opb;
      5'd9:    base_d = opa & opb;
      5'd10:   base_d = opb;
      default: base_ok = 1'b0;
    endcase
  end

`ifdef EXEC_ALU_MULDIV_EN
  logic [2:0]       mop_q;
  logic [LEN-1:0]   acc_q, lo_q, mc_q, dvd_q;
  logic             negq_q, negr_q, div0_q;
  logic [SH_W-1:0]  cnt_q;

  logic             m_op, sa, sb, ge;
  logic [LEN-1:0]   mag_a, mag_b, acc_d, lo_d, q_fix, r_fix, m_res;
  logic [LEN:0]     msum, shifted;
  logic [2*LEN-1:0] prod;

  assign m_op = (op_sel[4:3] == 2'b10);

  // Both units share acc/lo: multiply shifts the product right, divide shifts the dividend left.
  always_comb begin
    sa      = opa[LEN-1] & (op_sel[2] ? ~op_sel[0] : (op_sel[1:0] == 2'd1 || op_sel[1:0] == 2'd2));
    sb      = opb[LEN-1] & (op_sel[2] ? ~op_sel[0] : (op_sel[1:0] == 2'd1));
    mag_a   = sa ? -opa : opa;
    mag_b   = sb ? -opb : opb;
    msum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
    shifted = {acc_q, lo_q[LEN-1]};
    ge      = (shifted >= {1'b0, mc_q});
    if (mop_q[2]) begin
      acc_d = ge ? LEN'(shifted - {1'b0, mc_q}) : LEN'(shifted);
      lo_d  = {lo_q[LEN-2:0], ge};
    end else begin
      acc_d = msum[LEN:1];
      lo_d  = {msum[0], lo_q[LEN-1:1]};
    end
    prod = {acc_d, lo_d};
    if (negq_q) prod = -prod;
    q_fix = negq_q ? -lo_d : lo_d;
    r_fix = negr_q ? -acc_d : acc_d;
    if (div0_q) begin
      q_fix = '1;
      r_fix = dvd_q;
    end
    if (mop_q[2]) m_res = mop_q[1] ? r_fix : q_fix;
    else          m_res = (mop_q[1:0] == 2'd0) ? prod[LEN-1:0] : prod[2*LEN-1:LEN];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_tag_q   <= '0;
      zero_q      <= 1'b0;
      lt_q        <= 1'b0;
      ltu_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (rdy_in) begin
      if (accept) begin
        out_tag_q <= in_tag;
        zero_q    <= eq;
        lt_q      <= slt;
        ltu_q     <= sltu;
`ifdef EXEC_ALU_MULDIV_EN
        if (m_op) begin
          state_q     <= BUSY;
          out_valid_q <= 1'b0;
          illegal_q   <= 1'b0;
          mop_q       <= op_sel[2:0];
          acc_q       <= '0;
          lo_q        <= mag_a;
          mc_q        <= mag_b;
          dvd_q       <= opa;
          negq_q      <= sa ^ sb;
          negr_q      <= sa;
          div0_q      <= (opb == '0);
          cnt_q       <= '0;
        end else
`endif
        begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          result_q    <= base_ok ? base_d : '0;
          illegal_q   <= ~base_ok;
        end
      end else begin
        case (state_q)
          DONE: if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
`ifdef EXEC_ALU_MULDIV_EN
          BUSY: begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == SH_W'(LEN-1)) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= m_res;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_tag   = out_tag_q;
  assign flag_zero = zero_q;
  assign flag_lt   = lt_q;
  assign flag_ltu  = ltu_q;
  assign illegal   = illegal_q;
endmodule

// File: tb/tb_exec_alu_seq.sv
// Self-checking bench for exec_alu_seq: protocol-level reference model plus directed literal checks.
module tb_exec_alu_seq;
  localparam int unsigned LEN   = 32;
  localparam int unsigned TAG_W = 5;
`ifdef EXEC_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1, rdy_in = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0]       op_sel = '0;
  logic [LEN-1:0]   opa = '0, opb = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_ready, out_valid, flag_zero, flag_lt, flag_ltu, illegal;
  logic [LEN-1:0]   result;
  logic [TAG_W-1:0] out_tag;

  int unsigned n_chk = 0, n_pass = 0;

  exec_alu_seq #(.LEN(LEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .opa(opa), .opb(opb), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_tag(out_tag), .flag_zero(flag_zero),
    .flag_lt(flag_lt), .flag_ltu(flag_ltu), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic             ill;
    logic [31:0]      res;
    logic             z, lt, ltu;
    logic [TAG_W-1:0] tag;
    int               lat;
  } exp_t;

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      p;
    logic [63:0] up;
    e = '0;
    e.lat = 1;
    e.z   = (a == b);
    e.lt  = ($signed(a) < $signed(b));
    e.ltu = (a < b);
    up = {32'b0, a} * {32'b0, b};
    if (op <= 5'd10) begin
      case (op)
        5'd0:    e.res = a + b;
        5'd1:    e.res = a - b;
        5'd2:    e.res = a << b[4:0];
        5'd3:    e.res = {31'b0, e.lt};
        5'd4:    e.res = {31'b0, e.ltu};
        5'd5:    e.res = a ^ b;
        5'd6:    e.res = a >> b[4:0];
        5'd7:    e.res = $signed(a) >>> b[4:0];
        5'd8:    e.res = a | b;
        5'd9:    e.res = a & b;
        default: e.res = b;
      endcase
    end else if (MD && op >= 5'd16 && op <= 5'd23) begin
      e.lat = LEN + 1;
      case (op)
        5'd16: e.res = up[31:0];
        5'd17: begin p = longint'($signed(a)) * longint'($signed(b)); e.res = p[63:32]; end
        5'd18: begin p = longint'($signed(a)) * longint'({32'b0, b}); e.res = p[63:32]; end
        5'd19: e.res = up[63:32];
        5'd20: e.res = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a
                       : 32'($signed(a) / $signed(b));
        5'd21: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
        5'd22: e.res = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0
                       : 32'($signed(a) % $signed(b));
        default: e.res = (b == 0) ? a : a % b;
      endcase
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Compare process: tracks the one in-flight op by enabled-cycle age.
  exp_t cur;
  bit   exp_v = 1'b0, prev_en = 1'b0, prev_rst = 1'b0;
  int   age = 0;

  always @(negedge clk) begin
    logic eir;
    if (prev_rst) exp_v = 1'b0;
    else if (prev_en && exp_v) age++;
    if (!exp_v || age < cur.lat) begin
      chk("mon_out_valid_low", out_valid, 0);
    end else begin
      chk("mon_out_valid", out_valid, 1);
      chk("mon_result", result, cur.res);
      chk("mon_tag", out_tag, cur.tag);
      chk("mon_flags_ill", {flag_zero, flag_lt, flag_ltu, illegal}, {cur.z, cur.lt, cur.ltu, cur.ill});
    end
    eir = rdy_in && (!exp_v || (age >= cur.lat && out_ready));
    chk("mon_in_ready", in_ready, eir);
    if (!rst && rdy_in && exp_v && age >= cur.lat && out_ready) exp_v = 1'b0;
    if (!rst && in_valid && in_ready) begin
      cur     = model(op_sel, opa, opb);
      cur.tag = in_tag;
      exp_v   = 1'b1;
      age     = 0;
    end
    prev_en  = rdy_in && !rst;
    prev_rst = rst;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t);
    op_sel = op; opa = a; opb = b; in_tag = t; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
  endtask

  logic [4:0]  t_op  [11] = '{5'd2, 5'd3, 5'd4, 5'd6, 5'd8, 5'd9, 5'd10, 5'd0, 5'd1, 5'd11, 5'd31};
  logic [31:0] t_a   [11] = '{32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hF0F0_0000,
                              32'hFF00_FF00, 32'h1234_5678, 32'hFFFF_FFFF, 32'h55, 32'h5, 32'h5};
  logic [31:0] t_b   [11] = '{32'h21, 32'h1, 32'h1, 32'h4, 32'h0000_0F0F, 32'h0FF0_0FF0,
                              32'hCAFE_BABE, 32'h2, 32'h55, 32'h6, 32'h6};
  logic [31:0] t_exp [11] = '{32'h2, 32'h1, 32'h0, 32'h0800_0000, 32'hF0F0_0F0F, 32'h0F00_0F00,
                              32'hCAFE_BABE, 32'h1, 32'h0, 32'h0, 32'h0};
  logic        t_ill [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int n;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_tag_flags", {out_tag, flag_zero, flag_lt, flag_ltu, illegal}, 0);
    chk("reset_in_ready", in_ready, 1);

    issue(5'd0, 32'h7FFF_FFFF, 32'h1, 5'd3);
    chk("add_valid", out_valid, 1);
    chk("add_result", result, 32'h8000_0000);
    chk("add_tag", out_tag, 3);
    chk("add_lt_ltu", {flag_lt, flag_ltu}, 2'b00);
    drain();

    out_ready = 1'b1;
    op_sel = 5'd1; opa = 32'd5; opb = 32'd7; in_tag = 5'd9; in_valid = 1'b1;
    tick();
    chk("sub_result", result, 32'hFFFF_FFFE);
    chk("sub_lt_ltu", {flag_lt, flag_ltu}, 2'b11);
    chk("b2b_in_ready", in_ready, 1);
    op_sel = 5'd7; opa = 32'h8000_0000; opb = 32'd4; in_tag = 5'd10;
    tick();
    chk("sra_result", result, 32'hF800_0000);
    chk("sra_tag", out_tag, 10);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;

    issue(5'd5, 32'h0000_FF00, 32'h0000_0F0F, 5'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_result", result, 32'h0000_F00F);
      chk("hold_valid", out_valid, 1);
    end
    rdy_in = 1'b0; out_ready = 1'b1; in_valid = 1'b1; op_sel = 5'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("freeze_result", result, 32'h0000_F00F);
      chk("freeze_valid", out_valid, 1);
      chk("freeze_in_ready", in_ready, 0);
    end
    rdy_in = 1'b1; in_valid = 1'b0;
    tick();
    chk("hold_release", out_valid, 0);
    out_ready = 1'b0;

    for (int i = 0; i < 11; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 5'(i));
      chk("tbl_result", result, t_exp[i]);
      chk("tbl_illegal", illegal, t_ill[i]);
      if (i == 8) chk("tbl_zero_flag", flag_zero, 1);
      drain();
    end

`ifndef EXEC_ALU_MULDIV_EN
    issue(5'd16, 32'd3, 32'd4, 5'd1);
    chk("nomd_mul_valid", out_valid, 1);
    chk("nomd_mul_illegal", {illegal, result}, {1'b1, 32'h0});
    drain();
`else
    begin
      logic [4:0]  m_op  [4] = '{5'd17, 5'd20, 5'd21, 5'd22};
      logic [31:0] m_a   [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd1234, 32'hFFFF_FFF9};
      logic [31:0] m_b   [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd2};
      logic [31:0] m_exp [4] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      for (int i = 0; i < 4; i++) begin
        issue(m_op[i], m_a[i], m_b[i], 5'(20 + i));
        wait_valid(n);
        chk("md_latency", n, LEN);
        chk("md_result", result, m_exp[i]);
        chk("md_illegal", illegal, 0);
        drain();
      end
    end
    issue(5'd21, 32'd100, 32'd7, 5'd4);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("busy_rst_valid", out_valid, 0);
    chk("busy_rst_in_ready", in_ready, 1);
    repeat (40) tick();
    chk("busy_rst_no_stale", out_valid, 0);
`endif

    issue(5'd0, 32'd1, 32'd2, 5'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("done_rst_valid", out_valid, 0);
    chk("done_rst_regs", {result, out_tag}, 0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
